sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Writer side of the background/frame memory that the scan-out path reads with 3-bit palette indices.
- Two jobs: draws 16x16 sprites from a sprite ROM into a 160x120 index framebuffer (19200 entries, address = row*160 + col), and clears the whole buffer to one colour.
- One write per cycle. Handles transparency and clips pixels that fall off screen.
- Sits between game logic (start/clear requests) and the framebuffer write port.

Parameters:
- FB_W, 160, framebuffer width in pixels
- FB_H, 120, framebuffer height in pixels
- SPR_DIM, 16, sprite edge length (power of two)
- NUM_SPR, 8, number of sprites in the ROM
- TRANSP_IDX, 3'h7, ROM index treated as transparent

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  draw request, sampled only in IDLE
- clear  in  1  clear request, sampled only in IDLE
- spr_id  in  3  sprite number
- spr_x  in  8  sprite left column, 0..255
- spr_y  in  7  sprite top row, 0..127
- clear_color  in  3  fill index for clear
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- fb_we  out  1  framebuffer write enable
- fb_addr  out  15  framebuffer write address
- fb_data  out  3  framebuffer write data

Behaviour:
- Reset: all outputs 0, state IDLE. Reset is asynchronous, so fb_we drops immediately even mid-operation. No partial completion: done is not pulsed.
- States:
  - IDLE: waits for a request.
  - CLEAR: linear fill.
  - DRAW: pixel walk plus 1-stage ROM pipe.
  - FIN: done pulse, then back to IDLE.
- Request acceptance:
  - In IDLE, a request is accepted at the clock edge where it is sampled high (edge N).
  - On accept, spr_id, spr_x, spr_y and clear_color are latched. Later input changes have no effect on the running operation.
  - clear and start high together: clear wins and start is dropped (caller must reassert).
  - Requests while busy are ignored, not queued.
- busy is 1 from edge N until the FIN cycle ends. done is 1 only in the FIN cycle. busy and done overlap in the FIN cycle.
- CLEAR:
  - Address k (0..19199) is written with fb_data = clear_color in the cycle after edge N+k.
  - FIN occurs in the cycle after edge N+19200.
  - Address counter stops at 19199; it never writes 19200 or above.
- DRAW:
  - Pixel k = row*16 + col, k in 0..255, row-major.
  - The ROM address {id, row, col} is issued in the cycle after edge N+k. ROM data returns 1 cycle later.
  - The write slot for pixel k is the cycle after edge N+1+k.
  - Write target: px = spr_x + col, py = spr_y + row. Compute both 9 bits wide with no wrap.
  - fb_we = 1 only if px < FB_W and py < FB_H and the ROM index != TRANSP_IDX.
  - fb_addr = py*160 + px, fb_data = the ROM index.
  - Suppressed pixels still consume their slot, so timing is fixed: FIN in the cycle after edge N+257.
- fb_addr and fb_data are don't-care whenever fb_we = 0; the bench must not check them then.

Optional Feature:
- Macro: SPRITE_HFLIP_EN.
- When defined:
  - Adds input port hflip (1 bit), latched at accept.
  - If hflip is set, the ROM column becomes 15 - col; the screen column stays spr_x + col.
- When undefined:
  - No port is added.
  - Sprites are always drawn unflipped; timing is identical.

Decomposition:
- Shared package blit_pkg:
  - constants FB_W, FB_H, FB_SIZE = 19200, SPR_DIM, TRANSP_IDX
  - typedef pix_idx_t = logic [2:0]
  - typedef fb_addr_t = logic [14:0]
  - enum blit_state_t {IDLE, CLEAR, DRAW, FIN}
- Sub-module sprite_rom:
  - NUM_SPR*256 x 3-bit memory loaded by $readmemh("sprites.bin").
  - Synchronous 1-cycle read, inferable as BRAM.

Test Plan:
- Reset, then clear with clear_color=5 -> exactly 19200 writes to addresses 0..19199, all data 5; done at cycle N+19201; busy then 0.
- Sprite 0 (all opaque, index 2) at x=10, y=20 -> 256 writes; first write addr 3210, last addr 35*160+25=5625; done at N+258.
- Same sprite at x=150, y=110 -> 10x10 = 100 writes only; no write with px>=160 or py>=120; done still at N+258.
- Sprite 1 whose even columns are index 7 -> 128 writes, odd columns only, no data value 7.
- start pulsed mid-draw and start+clear together in IDLE -> the mid-draw start is ignored; the simultaneous request runs clear only.
- rst asserted at pixel 100 -> fb_we=0, busy=0 immediately, no done; a following start draws normally. With SPRITE_HFLIP_EN, hflip=1 puts ROM col 15 at screen col spr_x.

Source files
------------

// File: rtl/blit_pkg.sv
// Shared constants and types for the sprite blitter: framebuffer geometry,
// sprite ROM geometry, pixel/address types and the controller state encoding.
package blit_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_SIZE  = FB_W * FB_H;
  localparam int SPR_DIM  = 16;
  localparam int NUM_SPR  = 8;
  localparam int SPR_LOG2 = $clog2(SPR_DIM);
  localparam int SPR_PIX  = SPR_DIM * SPR_DIM;
  localparam int ROM_AW   = $clog2(NUM_SPR) + 2 * SPR_LOG2;

  localparam logic [2:0] TRANSP_IDX = 3'h7;

  typedef logic [2:0]  pix_idx_t;
  typedef logic [14:0] fb_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAW  = 2'd2,
    FIN   = 2'd3
  } blit_state_t;

endpackage

// File: rtl/sprite_rom.sv
// Sprite image store: NUM_SPR sprites of SPR_DIM x SPR_DIM palette indices,
// addressed {id, row, col}, synchronous single-cycle read (block-RAM style).
module sprite_rom
  import blit_pkg::*;
(
  input  logic              clk_i,
  input  logic [ROM_AW-1:0] addr_i,
  output logic [2:0]        data_o
);

  pix_idx_t mem [2**ROM_AW];

  always_ff @(posedge clk_i) begin
    data_o <= mem[addr_i];
  end

endmodule

// File: rtl/sprite_blitter.sv
// Framebuffer writer: clears the 160x120 index buffer to one colour or blits a
// 16x16 sprite with transparency and clipping. Define SPRITE_HFLIP_EN to add
// the hflip input (mirror the sprite horizontally).
module sprite_blitter
  import blit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clear,
  input  logic [2:0]  spr_id,
  input  logic [7:0]  spr_x,
  input  logic [6:0]  spr_y,
  input  logic [2:0]  clear_color,
`ifdef SPRITE_HFLIP_EN
  input  logic        hflip,
`endif
  output logic        busy,
  output logic        done,
  output logic        fb_we,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_data
);

  localparam fb_addr_t CLR_LAST = fb_addr_t'(FB_SIZE - 1);
  localparam fb_addr_t SPR_LAST = fb_addr_t'(SPR_PIX - 1);

  blit_state_t state_q;
  logic        busy_q;
  logic        done_q;
  logic        clr_we_q;
  logic        drain_q;
  fb_addr_t    cnt_q;
  logic [2:0]  id_q;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  pix_idx_t    color_q;
  logic        flip_q;
  logic        pv_q;
  logic        vis_q;
  fb_addr_t    addr_q;

  logic [SPR_LOG2-1:0] row;
  logic [SPR_LOG2-1:0] col;
  logic [SPR_LOG2-1:0] rom_col;
  logic [ROM_AW-1:0]   rom_addr;
  logic [8:0]          px_d;
  logic [8:0]          py_d;
  logic                vis_d;
  fb_addr_t            addr_d;
  pix_idx_t            rom_data;

  // Address stage: cnt_q walks the sprite row-major; screen position is
  // computed 9 bits wide so off-screen pixels are detected, never wrapped.
  always_comb begin
    row      = cnt_q[2*SPR_LOG2-1:SPR_LOG2];
    col      = cnt_q[SPR_LOG2-1:0];
    rom_col  = flip_q ? ~col : col;
    rom_addr = {id_q, row, rom_col};
    px_d     = {1'b0, x_q} + 9'(col);
    py_d     = {2'b00, y_q} + 9'(row);
    vis_d    = (px_d < 9'(FB_W)) && (py_d < 9'(FB_H));
    addr_d   = fb_addr_t'(py_d[6:0]) * fb_addr_t'(FB_W) + fb_addr_t'(px_d[7:0]);
  end

  sprite_rom u_rom (
    .clk_i  (clk),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clr_we_q <= 1'b0;
      drain_q  <= 1'b0;
      cnt_q    <= '0;
      id_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      color_q  <= '0;
      flip_q   <= 1'b0;
      pv_q     <= 1'b0;
      vis_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      pv_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear) begin
            state_q  <= CLEAR;
            busy_q   <= 1'b1;
            clr_we_q <= 1'b1;
            cnt_q    <= '0;
            color_q  <= clear_color;
          end else if (start) begin
            state_q <= DRAW;
            busy_q  <= 1'b1;
            drain_q <= 1'b0;
            cnt_q   <= '0;
            id_q    <= spr_id;
            x_q     <= spr_x;
            y_q     <= spr_y;
`ifdef SPRITE_HFLIP_EN
            flip_q  <= hflip;
`else
            flip_q  <= 1'b0;
`endif
          end
        end
        CLEAR: begin
          if (cnt_q == CLR_LAST) begin
            clr_we_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= FIN;
          end else begin
            cnt_q <= cnt_q + fb_addr_t'(1);
          end
        end
        DRAW: begin
          // drain_q covers the extra cycle the last ROM read needs to land.
          if (drain_q) begin
            drain_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            pv_q   <= 1'b1;
            vis_q  <= vis_d;
            addr_q <= addr_d;
            if (cnt_q == SPR_LAST) begin
              drain_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + fb_addr_t'(1);
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write stage: ROM data arrives alongside the pipelined position; a
  // suppressed pixel still occupies its slot, only the enable is dropped.
  assign fb_we   = clr_we_q | (pv_q & vis_q & (rom_data != TRANSP_IDX));
  assign fb_addr = clr_we_q ? cnt_q : addr_q;
  assign fb_data = clr_we_q ? color_q : (pv_q ? rom_data : 3'd0);
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: clears, clipped/transparent draws,
// request arbitration and asynchronous reset, checked against a write queue.
module tb_sprite_blitter;
  import blit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  spr_id = '0;
  logic [7:0]  spr_x = '0;
  logic [6:0]  spr_y = '0;
  logic [2:0]  clear_color = '0;
`ifdef SPRITE_HFLIP_EN
  logic        hflip = 1'b0;
`endif
  logic        busy;
  logic        done;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;

  sprite_blitter dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .clear       (clear),
    .spr_id      (spr_id),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .clear_color (clear_color),
`ifdef SPRITE_HFLIP_EN
    .hflip       (hflip),
`endif
    .busy        (busy),
    .done        (done),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard state: {cycle offset from accept edge, addr, data}
  logic [49:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          edge_cnt = 0;
  int          acc = 0;
  int          wr_cnt = 0;
  int          done_edge = 0;
  logic        done_seen = 1'b0;
  logic        busy_at_done = 1'b0;
  logic [14:0] first_addr = '0;
  logic [14:0] last_addr = '0;
  logic [2:0]  first_data = '0;

  function automatic logic [2:0] img(input int id, input int r, input int c);
    if (id == 0) return 3'd2;
    if (id == 1) return (c % 2 == 0) ? 3'd7 : 3'(r % 7);
    return 3'((id + r + c) % 8);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock: sample at negedge and score any framebuffer write
  task automatic tick();
    logic [49:0] got;
    logic [49:0] exp;
    @(negedge clk);
    edge_cnt++;
    if (done && !done_seen) begin
      done_seen    = 1'b1;
      done_edge    = edge_cnt;
      busy_at_done = busy;
    end
    if (fb_we) begin
      wr_cnt++;
      if (wr_cnt == 1) begin
        first_addr = fb_addr;
        first_data = fb_data;
      end
      last_addr = fb_addr;
      got = {32'(edge_cnt - acc), fb_addr, fb_data};
      exp = '1;
      if (exp_q.size() != 0) exp = exp_q.pop_front();
      vectors++;
      assert (got === exp) else begin
        miscompares++;
        $error("FAIL write: observed off=%0d addr=%0d data=%0d expected off=%0d addr=%0d data=%0d",
               got[49:18], got[17:3], got[2:0], exp[49:18], exp[17:3], exp[2:0]);
      end
    end
  endtask

  task automatic push_clear(input logic [2:0] c);
    for (int k = 0; k < FB_SIZE; k++) exp_q.push_back({32'(k), 15'(k), c});
  endtask

  task automatic push_draw(input int id, input int x, input int y, input bit hf, input int lim);
    for (int k = 0; k < SPR_PIX; k++) begin
      int r;
      int c;
      int px;
      int py;
      logic [2:0] v;
      r  = k / SPR_DIM;
      c  = k % SPR_DIM;
      v  = img(id, r, hf ? (SPR_DIM - 1 - c) : c);
      px = x + c;
      py = y + r;
      if (px < FB_W && py < FB_H && v != 3'd7 && (1 + k) <= lim)
        exp_q.push_back({32'(1 + k), 15'(py * FB_W + px), v});
    end
  endtask

  task automatic issue(input logic s, input logic c, input int id, input int x, input int y,
                       input logic [2:0] col, input bit hf);
    tick();
    start       = s;
    clear       = c;
    spr_id      = 3'(id);
    spr_x       = 8'(x);
    spr_y       = 7'(y);
    clear_color = col;
`ifdef SPRITE_HFLIP_EN
    hflip       = hf;
`else
    if (hf) $display("note: hflip requested but feature not built");
`endif
    acc        = edge_cnt + 1;
    wr_cnt     = 0;
    done_seen  = 1'b0;
    tick();
    start  = 1'b0;
    clear  = 1'b0;
    // scramble inputs: the running operation must use its latched copies
    spr_id      = 3'(id + 3);
    spr_x       = 8'(x + 37);
    spr_y       = 7'(y + 11);
    clear_color = ~col;
  endtask

  task automatic wait_done(input int budget, input int exp_off, input string tag);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      tick();
      n++;
    end
    check({tag, " done_seen"}, done_seen, 1);
    check({tag, " done_cycle"}, done_edge - acc, exp_off);
    check({tag, " busy_with_done"}, busy_at_done, 1);
    tick();
    check({tag, " busy_after"}, busy, 0);
    check({tag, " queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #1;
    for (int a = 0; a < 2 ** ROM_AW; a++)
      dut.u_rom.mem[a] = img(a / SPR_PIX, (a / SPR_DIM) % SPR_DIM, a % SPR_DIM);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset fb_we", fb_we, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // full clear to colour 5
    push_clear(3'd5);
    issue(1'b0, 1'b1, 0, 0, 0, 3'd5, 1'b0);
    wait_done(20000, 19200, "clear5");
    check("clear5 writes", wr_cnt, 19200);
    check("clear5 last_addr", last_addr, 19199);

    // opaque sprite 0 at (10,20), with an ignored start pulse mid-draw
    push_draw(0, 10, 20, 1'b0, 999);
    issue(1'b1, 1'b0, 0, 10, 20, 3'd0, 1'b0);
    for (int i = 0; i < 50; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(300, 257, "spr0");
    check("spr0 writes", wr_cnt, 256);
    check("spr0 first_addr", first_addr, 3210);
    check("spr0 last_addr", last_addr, 5625);
    check("spr0 first_data", first_data, 2);

    // clipped at bottom-right corner
    push_draw(0, 150, 110, 1'b0, 999);
    issue(1'b1, 1'b0, 0, 150, 110, 3'd0, 1'b0);
    wait_done(300, 257, "clip");
    check("clip writes", wr_cnt, 100);
    check("clip first_addr", first_addr, 17750);
    check("clip last_addr", last_addr, 19199);

    // transparent even columns
    push_draw(1, 40, 30, 1'b0, 999);
    issue(1'b1, 1'b0, 1, 40, 30, 3'd0, 1'b0);
    wait_done(300, 257, "transp");
    check("transp writes", wr_cnt, 128);
    check("transp first_addr", first_addr, 4841);
    check("transp first_data", first_data, 0);
    check("transp last_addr", last_addr, 7255);

    // start and clear together: clear only
    push_clear(3'd3);
    issue(1'b1, 1'b1, 0, 10, 20, 3'd3, 1'b0);
    wait_done(20000, 19200, "both");
    check("both writes", wr_cnt, 19200);

    // asynchronous reset after pixel 99 has been written
    push_draw(0, 0, 0, 1'b0, 100);
    issue(1'b1, 1'b0, 0, 0, 0, 3'd0, 1'b0);
    for (int i = 0; i < 100; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("rst fb_we", fb_we, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rst no_done", done_seen, 0);
    check("rst writes", wr_cnt, 100);
    check("rst queue_left", exp_q.size(), 0);

    // normal draw after the aborted one
    push_draw(0, 100, 50, 1'b0, 999);
    issue(1'b1, 1'b0, 0, 100, 50, 3'd0, 1'b0);
    wait_done(300, 257, "after_rst");
    check("after_rst writes", wr_cnt, 256);
    check("after_rst first_addr", first_addr, 8100);

`ifdef SPRITE_HFLIP_EN
    // mirrored: ROM column 15 lands at screen column spr_x
    push_draw(2, 20, 5, 1'b1, 999);
    issue(1'b1, 1'b0, 2, 20, 5, 3'd0, 1'b1);
    wait_done(300, 257, "hflip");
    check("hflip first_addr", first_addr, 820);
    check("hflip first_data", first_data, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
